sub64_serial: RTL and testbench
===============================

# sub64_serial

Multi-cycle WIDTH-bit subtractor that computes `diff = a - b - b_in` one 4-bit slice per clock, LSB slice first, through a single 4-bit borrow-chain slice. It is the subtract-direction counterpart of the ripple-carry adder family. It serves datapaths that need a wide difference, borrow and flags without paying for a full-width borrow chain. Operands are captured on a start handshake, and the result is held stable until the next accepted start.

## Interface
- `WIDTH`, 64: operand and result width. Must be a multiple of 4 and ≥ 8.
- `SLICES`, WIDTH/4: derived slice count; not overridable.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request. Sampled only when `busy`=0.
- `a`  in  WIDTH  minuend. Captured on accepted start.
- `b`  in  WIDTH  subtrahend. Captured on accepted start.
- `b_in`  in  1  borrow-in. Captured on accepted start.
- `busy`  out  1  high while slices are being processed.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `diff`  out  WIDTH  result. Held until the next accepted start completes.
- `b_out`  out  1  borrow out of the MSB slice. Equals 1 iff unsigned a < b + b_in.
- `zero`  out  1  high iff `diff` == 0.
- `ovf`  out  1  high iff the signed result a − b − b_in lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].

## Operation
- **FSM states: IDLE, RUN, DONE.**
- **IDLE:**
  - With `start`=1: capture a, b and b_in into shift registers, clear the slice counter, load borrow with b_in, then go to RUN.
  - Otherwise: hold.
- **RUN:**
  - Each cycle, the slice computes the low nibbles: `{borrow', d4} = a[3:0] − b[3:0] − borrow`.
  - d4 shifts into the top of the result register; the a and b registers shift right by 4.
  - The counter increments.
  - After the slice with counter == SLICES−1, go to DONE.
- **DONE:** lasts exactly one cycle with `done`=1.
  - `start`=1 in DONE is accepted, with capture as in IDLE, and the FSM goes directly to RUN.
  - Otherwise the FSM returns to IDLE.
- **Output visibility:** `diff`, `b_out`, `zero` and `ovf` update only on the cycle entering DONE. Partial results are never visible on `diff`.
- **`ovf` computation:** carry into the MSB xor carry out of the MSB, in the a + ~b + ~b_in formulation. Equivalently: (a[MSB] ≠ b[MSB]) and (diff[MSB] ≠ a[MSB]), evaluated on the final slice.
- **Busy behaviour:** `start` while in RUN is ignored and not queued. Operand inputs are don't-care except on the capture cycle.
- **Width rule:** all arithmetic is modulo 2^WIDTH, and `diff` wraps. For example, 0 − 1 = all ones with `b_out`=1.

## Timing
- **Reset (`rst_n`=0, any state, including mid-RUN):** immediately forces IDLE, `busy`=0, `done`=0, `diff`=0, `b_out`=0, `zero`=1, `ovf`=0, counter=0. Any in-flight operation is discarded; there is no `done` for it.
- **Latency:** start sampled at edge E. Then:
  - `busy`=1 from E until E+SLICES.
  - Slices are processed on edges E+1 … E+SLICES.
  - `done`=1 and outputs are valid in the cycle after edge E+SLICES; `busy`=0 in that cycle.
  - With WIDTH=64, results are available 16 edges after capture.
- **Throughput:** back-to-back operation via start-in-DONE gives one result per SLICES+1 cycles.
- **Output updates:** `busy` and `done` are registered, never combinational from `start`. Flags are registered together with `diff`.

## Structure
- **Shared package `arith_pkg`:**
  - Constant SLICE_W = 4.
  - State enum `sub_state_t` {IDLE, RUN, DONE}.
  - Function `clog2` for the counter width ($clog2(SLICES)).
- **Sub-module `sub4_slice`:** combinational 4-bit borrow-ripple subtractor with ports (b_out, d[3:0], x[3:0], y[3:0], b_in). It is built from four full-adder cells with y inverted and the carry inverted at each end. It is instantiated once.
- **Top level:** FSM, counter, the three shift registers, borrow flop and output registers.

## Test plan
- **Basic subtract:** a=5, b=3, b_in=0, start → after 16 edges `done` pulses; diff=2, b_out=0, zero=0, ovf=0.
- **Unsigned underflow:** a=0, b=1, b_in=0 → diff=0xFFFF_FFFF_FFFF_FFFF, b_out=1, zero=0, ovf=0.
- **Signed overflow:** a=0x8000_0000_0000_0000, b=1 → diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, b_out=0.
  - Also: a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF → diff=0x8000_0000_0000_0000, ovf=1.
- **Borrow-in and zero:** a=10, b=9, b_in=1 → diff=0, zero=1, b_out=0.
  - Also: a=b=0x1234_5678_9ABC_DEF0 → zero=1.
- **Handshake:**
  - A second start pulsed mid-RUN is ignored: exactly one `done`, result from the first operands.
  - Start held high in the DONE cycle → second operation accepted; its `done` arrives 17 cycles after the first `done`.
- **Reset mid-operation:** assert `rst_n`=0 at slice 7 → outputs take their reset values immediately; no `done` is produced. After release, a fresh 5−3 completes normally.

Source files
------------

// File: rtl/sub64_serial_pkg.sv
// Shared arithmetic definitions for the serial subtractor: slice width, FSM
// state encoding and the counter-width helper.
package arith_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

   // Never narrower than one bit, even for a single-slice datapath.
   function automatic int clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit borrow-ripple subtractor: x - y - b_in built as
// x + ~y + ~b_in on full-adder cells, with the carry inverted at both ends.
module sub4_slice
   import arith_pkg::*;
(
   output logic               b_out,
   output logic [SLICE_W-1:0] d,
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   input  logic               b_in
);

   logic [SLICE_W:0] c;

   assign c[0] = ~b_in;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      logic p;
      assign p      = x[i] ^ ~y[i];
      assign d[i]   = p ^ c[i];
      assign c[i+1] = (x[i] & ~y[i]) | (c[i] & p);
   end

   assign b_out = ~c[SLICE_W];

endmodule

// File: rtl/sub64_serial.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - b_in, one 4-bit slice per
// clock, LSB first, through a single shared borrow-chain slice.
module sub64_serial
   import arith_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             zero,
   output logic             ovf
);

   localparam int SLICES = WIDTH / SLICE_W;
   localparam int CW     = clog2(SLICES);
   localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

   sub_state_t                 state;
   logic [CW-1:0]              cnt;
   logic [WIDTH-1:0]           a_sr;
   logic [WIDTH-1:0]           b_sr;
   logic [WIDTH-SLICE_W-1:0]   d_sr;
   logic                       borrow;
   logic                       a_msb;
   logic                       b_msb;

   logic                       s_bo;
   logic [SLICE_W-1:0]         s_d;
   logic [WIDTH-1:0]           d_next;
   logic                       accept;

   sub4_slice u_slice (
      .b_out (s_bo),
      .d     (s_d),
      .x     (a_sr[SLICE_W-1:0]),
      .y     (b_sr[SLICE_W-1:0]),
      .b_in  (borrow)
   );

   // Fresh nibble enters at the top; on the last slice this is the full result.
   assign d_next = {s_d, d_sr};
   assign accept = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         d_sr   <= '0;
         borrow <= 1'b0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         b_out  <= 1'b0;
         zero   <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            a_sr   <= a;
            b_sr   <= b;
            borrow <= b_in;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
         end else begin
            case (state)
               RUN: begin
                  a_sr   <= {{SLICE_W{1'b0}}, a_sr[WIDTH-1:SLICE_W]};
                  b_sr   <= {{SLICE_W{1'b0}}, b_sr[WIDTH-1:SLICE_W]};
                  d_sr   <= d_next[WIDTH-1:SLICE_W];
                  borrow <= s_bo;
                  cnt    <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     // Outputs and flags only move here, so no partial result leaks out.
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     diff  <= d_next;
                     b_out <= s_bo;
                     zero  <= (d_next == '0);
                     ovf   <= (a_msb != b_msb) && (d_next[WIDTH-1] != a_msb);
                  end
               end
               DONE:    state <= IDLE;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sub64_serial.sv
// Self-checking bench for sub64_serial: directed corner cases, handshake and
// reset scenarios, and random operands against a plain-arithmetic model.
module tb_sub64_serial;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [63:0] a;
   logic [63:0] b;
   logic        b_in;
   logic        busy;
   logic        done;
   logic [63:0] diff;
   logic        b_out;
   logic        zero;
   logic        ovf;

   int checks   = 0;
   int failures = 0;

   sub64_serial #(.WIDTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .b_out (b_out),
      .zero  (zero),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: wide unsigned subtraction for diff/borrow, signed range test for overflow.
   task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                        output logic [63:0] md, output logic mbo, output logic mz,
                        output logic mov);
      logic [64:0]        u;
      logic signed [65:0] s;
      u   = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
      s   = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb}) - $signed({65'd0, mbin});
      md  = u[63:0];
      mbo = u[64];
      mz  = (u[63:0] == 64'd0);
      mov = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
   endtask

   task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic ibin);
      @(negedge clk);
      a = ia; b = ib; b_in = ibin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = '0; b = '0; b_in = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
   endtask

   task automatic check_result(input string tag, input logic [63:0] ea, input logic [63:0] eb,
                               input logic ebin);
      logic [63:0] ed;
      logic        ebo, ez, eov;
      model(ea, eb, ebin, ed, ebo, ez, eov);
      chk({tag, ".diff"}, diff, ed);
      chk({tag, ".b_out"}, {63'd0, b_out}, {63'd0, ebo});
      chk({tag, ".zero"}, {63'd0, zero}, {63'd0, ez});
      chk({tag, ".ovf"}, {63'd0, ovf}, {63'd0, eov});
   endtask

   task automatic run_check(input string tag, input logic [63:0] ra, input logic [63:0] rb,
                            input logic rbin);
      int          n;
      logic [63:0] held;
      issue(ra, rb, rbin);
      chk({tag, ".busy_run"}, {63'd0, busy}, 64'd1);
      wait_done(n);
      chk({tag, ".latency"}, 64'(n), 64'd16);
      chk({tag, ".busy_done"}, {63'd0, busy}, 64'd0);
      check_result(tag, ra, rb, rbin);
      held = diff;
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
      chk({tag, ".held"}, diff, held);
   endtask

   initial begin
      int          n;
      int          ndone;
      logic [63:0] ra, rb;
      logic [63:0] prev;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", {63'd0, busy}, 64'd0);
      chk("rst.done", {63'd0, done}, 64'd0);
      chk("rst.diff", diff, 64'd0);
      chk("rst.zero", {63'd0, zero}, 64'd1);
      chk("rst.b_out", {63'd0, b_out}, 64'd0);
      chk("rst.ovf", {63'd0, ovf}, 64'd0);
      @(negedge clk); rst_n = 1'b1;

      run_check("basic", 64'd5, 64'd3, 1'b0);
      run_check("underflow", 64'd0, 64'd1, 1'b0);
      run_check("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
      run_check("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      run_check("bin_zero", 64'd10, 64'd9, 1'b1);
      run_check("eq_zero", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
      run_check("bin_wrap", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      run_check("min_bin", 64'h8000_0000_0000_0000, 64'd0, 1'b1);

      // Partial results must never appear on diff while running.
      issue(64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 1'b0);
      prev = 64'h0;  // previous result of min_bin is 0x7FFF...: re-read via model below
      begin
         logic [63:0] pd; logic pbo, pz, pov;
         model(64'h8000_0000_0000_0000, 64'd0, 1'b1, pd, pbo, pz, pov);
         prev = pd;
      end
      repeat (8) @(posedge clk);
      #1;
      chk("partial.diff_held", diff, prev);
      wait_done(n);
      chk("partial.latency", 64'(n + 8), 64'd16);
      check_result("partial", 64'hFFFF_0000_FFFF_0000, 64'h0123_4567_89AB_CDEF, 1'b0);

      // Start during RUN is ignored and not queued.
      issue(64'd100, 64'd1, 1'b0);
      repeat (4) @(posedge clk);
      #1; a = 64'd7; b = 64'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(n);
      chk("ignore.latency", 64'(n + 5), 64'd16);
      check_result("ignore", 64'd100, 64'd1, 1'b0);
      ndone = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("ignore.extra_done", 64'(ndone), 64'd0);
      chk("ignore.idle_busy", {63'd0, busy}, 64'd0);

      // Back-to-back: start held in the DONE cycle.
      issue(64'd50, 64'd20, 1'b0);
      wait_done(n);
      check_result("b2b1", 64'd50, 64'd20, 1'b0);
      a = 64'd3; b = 64'd5; b_in = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b.done_drop", {63'd0, done}, 64'd0);
      chk("b2b.busy", {63'd0, busy}, 64'd1);
      wait_done(n);
      chk("b2b.spacing", 64'(n + 1), 64'd17);
      check_result("b2b2", 64'd3, 64'd5, 1'b1);

      // Reset in the middle of an operation.
      issue(64'hDEAD_BEEF_0000_0001, 64'd2, 1'b0);
      repeat (7) @(posedge clk);
      #1; rst_n = 1'b0;
      #1;
      chk("midrst.busy", {63'd0, busy}, 64'd0);
      chk("midrst.done", {63'd0, done}, 64'd0);
      chk("midrst.diff", diff, 64'd0);
      chk("midrst.zero", {63'd0, zero}, 64'd1);
      chk("midrst.b_out", {63'd0, b_out}, 64'd0);
      chk("midrst.ovf", {63'd0, ovf}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      ndone = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("midrst.no_done", 64'(ndone), 64'd0);
      run_check("post_rst", 64'd5, 64'd3, 1'b0);

      // Random operands, with equal-operand and sign-boundary cases mixed in.
      for (int i = 0; i < 24; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (i % 6 == 1) rb = ra;
         if (i % 6 == 2) rb[63] = ~ra[63];
         run_check("rand", ra, rb, 1'($urandom_range(1, 0)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
